// File: rtl/dsp48a1_mac_ctrl.sv
// rtl/dsp48a1_mac_ctrl.sv - dot-product sequencer feeding a DSP48A1 configured as an unsigned MAC
// (A1REG=1, MREG=1, PREG=1, OPMODEREG=1); issues terms, tracks OPMODE per slot, captures the sum.
module dsp48a1_mac_ctrl #(
   parameter int DW     = 18,
   parameter int PW     = 48,
   parameter int LW     = 16,
   parameter int P_LAT  = 3,
   parameter int OP_DLY = 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic [LW-1:0] len,
   output logic          busy,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_a,
   input  logic [DW-1:0] in_b,
   output logic [DW-1:0] dsp_a,
   output logic [DW-1:0] dsp_b,
   output logic [7:0]    dsp_opmode,
   output logic          dsp_ce,
   input  logic [PW-1:0] dsp_p,
   output logic [PW-1:0] result,
   output logic          result_valid
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   localparam int         DCW      = $clog2(P_LAT + 2);
   localparam logic [7:0] OP_ZERO  = 8'h00;
   localparam logic [7:0] OP_HOLD  = 8'h08;
   localparam logic [7:0] OP_FIRST = 8'h01;
   localparam logic [7:0] OP_ACC   = 8'h09;

   state_t         state_q, state_d;
   logic [LW-1:0]  len_q, len_d;
   logic [LW-1:0]  cnt_q, cnt_d;
   logic [DCW-1:0] dcnt_q, dcnt_d;
   logic           first_q, first_d;
   logic           zlen_q, zlen_d;
   logic [DW-1:0]  a_q, a_d;
   logic [DW-1:0]  b_q, b_d;
   logic [PW-1:0]  res_q, res_d;
   logic [7:0]     op_in;
   logic [7:0]     op_sr_q [OP_DLY+1];
   logic           accept;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      dcnt_d   = dcnt_q;
      first_d  = first_q;
      zlen_d   = zlen_q;
      a_d      = '0;
      b_d      = '0;
      res_d    = res_q;
      in_ready = (state_q == LOAD) && (cnt_q < len_q);
      accept   = in_valid && in_ready;
      // Non-term slots keep the accumulator once it holds a real partial sum.
      op_in    = first_q ? OP_HOLD : OP_ZERO;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_d   = len;
               cnt_d   = '0;
               first_d = 1'b0;
               res_d   = '0;
               zlen_d  = (len == '0);
               state_d = (len == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               a_d     = in_a;
               b_d     = in_b;
               op_in   = first_q ? OP_ACC : OP_FIRST;
               first_d = 1'b1;
               cnt_d   = cnt_q + LW'(1);
               if (cnt_q + LW'(1) == len_q) begin
                  state_d = DRAIN;
                  dcnt_d  = DCW'(P_LAT);
               end
            end
         end
         DRAIN: begin
            if (dcnt_q == '0) begin
               res_d   = dsp_p;
               state_d = DONE;
            end else begin
               dcnt_d = dcnt_q - DCW'(1);
            end
         end
         DONE: begin
            zlen_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         dcnt_q  <= '0;
         first_q <= 1'b0;
         zlen_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         for (int i = 0; i <= OP_DLY; i++) op_sr_q[i] <= OP_ZERO;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         dcnt_q     <= dcnt_d;
         first_q    <= first_d;
         zlen_q     <= zlen_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         // Stage 0 lines up with dsp_a/dsp_b; the tap OP_DLY stages later matches OPMODEREG.
         op_sr_q[0] <= op_in;
         for (int i = 1; i <= OP_DLY; i++) op_sr_q[i] <= op_sr_q[i-1];
      end
   end

   assign busy         = (state_q != IDLE);
   assign dsp_ce       = busy && !zlen_q;
   assign dsp_a        = a_q;
   assign dsp_b        = b_q;
   assign dsp_opmode   = op_sr_q[OP_DLY];
   assign result       = res_q;
   assign result_valid = (state_q == DONE);

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// tb/tb_dsp48a1_mac_ctrl.sv - directed bench for dsp48a1_mac_ctrl with a behavioural DSP48A1 MAC slice
module tb_dsp48a1_mac_ctrl;

   localparam int DW = 18;
   localparam int PW = 48;
   localparam int LW = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          busy;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_a = '0;
   logic [DW-1:0] in_b = '0;
   logic [DW-1:0] dsp_a;
   logic [DW-1:0] dsp_b;
   logic [7:0]    dsp_opmode;
   logic          dsp_ce;
   logic [PW-1:0] dsp_p;
   logic [PW-1:0] result;
   logic          result_valid;

   dsp48a1_mac_ctrl #(.DW(DW), .PW(PW), .LW(LW), .P_LAT(3), .OP_DLY(1)) dut (
      .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
      .dsp_p(dsp_p), .result(result), .result_valid(result_valid)
   );

   always #5 CLK = ~CLK;

   // DSP48A1 slice: A1/B1, M, OPMODE and P registers, all on the shared clock enable.
   logic [DW-1:0] a1 = '0, b1 = '0;
   logic [PW-1:0] m = '0, p = '0;
   logic [7:0]    opr = '0;
   always @(posedge CLK) begin
      if (dsp_ce) begin
         a1  <= dsp_a;
         b1  <= dsp_b;
         m   <= PW'(a1) * PW'(b1);
         opr <= dsp_opmode;
         p   <= ((opr[1:0] == 2'b01) ? m : '0) + ((opr[3:2] == 2'b10) ? p : '0);
      end
   end
   assign dsp_p = p;

   int         cyc = 0;
   int         rv_cnt = 0;
   bit         rec_en = 0;
   bit         ce_seen = 0;
   logic [7:0] ops[$];
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (result_valid) rv_cnt <= rv_cnt + 1;
      if (rec_en && dsp_ce) begin
         ops.push_back(dsp_opmode);
         ce_seen <= 1'b1;
      end
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Opmodes from the first term slot to the last term slot, packed oldest-first.
   function automatic logic [63:0] pack_ops();
      int         f = -1;
      int         l = -1;
      logic [63:0] v = '0;
      foreach (ops[i]) if (ops[i][0]) begin
         if (f < 0) f = i;
         l = i;
      end
      if (f >= 0) for (int i = f; i <= l; i++) v = {v[55:0], ops[i]};
      return v;
   endfunction

   logic [DW-1:0] ta [4];
   logic [DW-1:0] tb_ [4];
   int            gp [4];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_job(input string tag, input int lv, input int n, input int dup_k,
                          input logic [PW-1:0] exp, input logic [63:0] exp_ops);
      int t_acc;
      int w;
      int rv0;
      ops.delete();
      ce_seen = 0;
      rec_en  = 1;
      rv0     = rv_cnt;
      start   = 1'b1;
      len     = LW'(lv);
      t_acc   = cyc;
      tick();
      start = 1'b0;
      len   = '0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b0;
         repeat (gp[k]) tick();
         in_valid = 1'b1;
         in_a     = ta[k];
         in_b     = tb_[k];
         if (k == dup_k) begin
            start = 1'b1;
            len   = LW'(5);
         end
         w = 0;
         while (!in_ready && w < 20) begin
            tick();
            w++;
         end
         chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
         t_acc = cyc;
         tick();
         in_valid = 1'b0;
         start    = 1'b0;
         len      = '0;
      end
      chk({tag, "_rdy_low"}, 64'(in_ready), 64'd0);
      w = 0;
      while (!result_valid && w < 30) begin
         tick();
         w++;
      end
      chk({tag, "_lat"}, 64'(cyc - t_acc), (n == 0) ? 64'd1 : 64'd5);
      chk({tag, "_res"}, 64'(result), 64'(exp));
      if (n == 0) chk({tag, "_ce"}, 64'(ce_seen), 64'd0);
      else        chk({tag, "_ops"}, pack_ops(), exp_ops);
      tick();
      rec_en = 0;
      chk({tag, "_rv_once"}, 64'(rv_cnt - rv0), 64'd1);
      chk({tag, "_idle"}, {62'd0, busy, result_valid}, 64'd0);
      chk({tag, "_hold"}, 64'(result), 64'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RST = 1'b1;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rdy", 64'(in_ready), 64'd0);
      chk("rst_rv", 64'(result_valid), 64'd0);
      chk("rst_res", 64'(result), 64'd0);
      chk("rst_ab", {28'd0, dsp_a, dsp_b}, 64'd0);
      chk("rst_op", 64'(dsp_opmode), 64'd0);
      chk("rst_ce", 64'(dsp_ce), 64'd0);
      RST = 1'b0;
      tick();

      // Stray in_valid while idle must not be taken.
      in_valid = 1'b1;
      in_a = 18'd5;
      in_b = 18'd5;
      tick();
      chk("idle_rdy", 64'(in_ready), 64'd0);
      tick();
      in_valid = 1'b0;

      ta = '{18'd2, 18'd4, 18'd1, 18'd0};
      tb_ = '{18'd3, 18'd5, 18'd7, 18'd0};
      gp = '{0, 0, 0, 0};
      run_job("b2b", 3, 3, -1, 48'd33, 64'h010909);

      ta = '{18'd10, 18'd3, 18'd0, 18'd0};
      tb_ = '{18'd10, 18'd3, 18'd0, 18'd0};
      gp = '{0, 2, 0, 0};
      run_job("bubble", 2, 2, -1, 48'd109, 64'h01080809);

      run_job("len0", 0, 0, -1, 48'd0, 64'd0);

      ta = '{18'd1, 18'd3, 18'd5, 18'd0};
      tb_ = '{18'd2, 18'd4, 18'd6, 18'd0};
      gp = '{1, 0, 0, 0};
      run_job("dupstart", 3, 3, 1, 48'd44, 64'h010909);

      // Abort a len=4 job after two terms.
      start = 1'b1;
      len   = LW'(4);
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in_a = 18'd7;
      in_b = 18'd7;
      tick();
      in_a = 18'd8;
      in_b = 18'd8;
      tick();
      in_valid = 1'b0;
      RST = 1'b1;
      tick();
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_op", 64'(dsp_opmode), 64'd0);
      chk("abort_ce", 64'(dsp_ce), 64'd0);
      RST = 1'b0;
      begin
         int rv0;
         rv0 = rv_cnt;
         repeat (10) tick();
         chk("abort_no_rv", 64'(rv_cnt - rv0), 64'd0);
      end

      ta = '{18'd6, 18'd0, 18'd0, 18'd0};
      tb_ = '{18'd7, 18'd0, 18'd0, 18'd0};
      gp = '{0, 0, 0, 0};
      run_job("post_rst", 1, 1, -1, 48'd42, 64'h01);

      ta = '{18'h3FFFF, 18'd0, 18'd0, 18'd0};
      tb_ = '{18'h3FFFF, 18'd0, 18'd0, 18'd0};
      run_job("maxop", 1, 1, -1, 48'hF_FFF8_0001, 64'h01);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
